// File: rtl/ahb_master_sel.sv
// Two-master AHB-lite selector: arbitrates the single system master port between CM0 (0)
// and the comm controller (1), switching owners only at transfer boundaries.
module ahb_master_sel #(
  parameter logic RESET_OWNER = 1'b0,
  parameter int   AW          = 32,
  parameter int   DW          = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [1:0]    hmsel,
  input  logic [AW-1:0] m0_haddr,
  input  logic [1:0]    m0_htrans,
  input  logic          m0_hwrite,
  input  logic [2:0]    m0_hsize,
  input  logic [DW-1:0] m0_hwdata,
  output logic [DW-1:0] m0_hrdata,
  output logic          m0_hready,
  output logic          m0_hresp,
  input  logic [AW-1:0] m1_haddr,
  input  logic [1:0]    m1_htrans,
  input  logic          m1_hwrite,
  input  logic [2:0]    m1_hsize,
  input  logic [DW-1:0] m1_hwdata,
  output logic [DW-1:0] m1_hrdata,
  output logic          m1_hready,
  output logic          m1_hresp,
  output logic [AW-1:0] s_haddr,
  output logic [1:0]    s_htrans,
  output logic          s_hwrite,
  output logic [2:0]    s_hsize,
  output logic [DW-1:0] s_hwdata,
  input  logic [DW-1:0] s_hrdata,
  input  logic          s_hready,
  input  logic          s_hresp,
  output logic          owner,
  output logic          switching
);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [0:0]    st;
  logic          own;
  logic          dph_vld;
  logic          dph_mst;

  logic [AW-1:0] m_haddr  [2];
  logic [1:0]    m_htrans [2];
  logic          m_hwrite [2];
  logic [2:0]    m_hsize  [2];

  logic [1:0]    pend_vld;
  logic [AW-1:0] pend_addr  [2];
  logic [1:0]    pend_trans [2];
  logic          pend_write [2];
  logic [2:0]    pend_size  [2];

  logic [AW-1:0] hold_addr;
  logic          hold_write;
  logic [2:0]    hold_size;

  logic [AW-1:0] bus_addr;
  logic [1:0]    bus_trans;
  logic          bus_write;
  logic [2:0]    bus_size;

  logic          req_mst;
  logic          pend_own;
  logic [1:0]    hr;
  logic [1:0]    cap;
  logic [1:0]    replay;

  assign m_haddr[0]  = m0_haddr;
  assign m_haddr[1]  = m1_haddr;
  assign m_htrans[0] = m0_htrans;
  assign m_htrans[1] = m1_htrans;
  assign m_hwrite[0] = m0_hwrite;
  assign m_hwrite[1] = m1_hwrite;
  assign m_hsize[0]  = m0_hsize;
  assign m_hsize[1]  = m1_hsize;

  // Reserved hmsel encodings keep whoever owns the bus now.
  assign req_mst  = hmsel[1] ? own : hmsel[0];
  assign pend_own = pend_vld[own];

  always_comb begin
    bus_addr  = hold_addr;
    bus_trans = 2'b00;
    bus_write = hold_write;
    bus_size  = hold_size;
    if (st == RUN) begin
      if (pend_own) begin
        bus_addr  = pend_addr[own];
        bus_trans = pend_trans[own];
        bus_write = pend_write[own];
        bus_size  = pend_size[own];
      end else begin
        bus_addr  = m_haddr[own];
        bus_trans = m_htrans[own];
        bus_write = m_hwrite[own];
        bus_size  = m_hsize[own];
      end
    end
  end

  assign s_haddr  = bus_addr;
  assign s_htrans = rstn ? bus_trans : 2'b00;
  assign s_hwrite = bus_write;
  assign s_hsize  = bus_size;
  assign s_hwdata = dph_mst ? m1_hwdata : m0_hwdata;

  // A master's data phase takes precedence over its own parked entry.
  always_comb begin
    hr = 2'b11;
    for (int i = 0; i < 2; i++) begin
      if (dph_vld && (dph_mst == 1'(i)))
        hr[i] = s_hready;
      else if (pend_vld[i])
        hr[i] = 1'b0;
      else if ((own == 1'(i)) && (st == RUN))
        hr[i] = s_hready;
    end
  end

  always_comb begin
    cap    = 2'b00;
    replay = 2'b00;
    for (int i = 0; i < 2; i++) begin
      cap[i]    = hr[i] && m_htrans[i][1] &&
                  !((own == 1'(i)) && (st == RUN) && !pend_own);
      replay[i] = (own == 1'(i)) && (st == RUN) && pend_vld[i] && s_hready;
    end
  end

  assign m0_hready = hr[0] | ~rstn;
  assign m1_hready = hr[1] | ~rstn;
  assign m0_hrdata = dph_mst ? '0 : s_hrdata;
  assign m1_hrdata = dph_mst ? s_hrdata : '0;
  assign m0_hresp  = dph_vld && !dph_mst && s_hresp;
  assign m1_hresp  = dph_vld &&  dph_mst && s_hresp;
  assign owner     = own;
  assign switching = (st == DRAIN);

  // A fresh capture overrides a same-cycle replay because the old entry is then on the bus.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_vld <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        pend_addr[i]  <= '0;
        pend_trans[i] <= 2'b00;
        pend_write[i] <= 1'b0;
        pend_size[i]  <= 3'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (cap[i]) begin
          pend_vld[i]   <= 1'b1;
          pend_addr[i]  <= m_haddr[i];
          pend_trans[i] <= m_htrans[i];
          pend_write[i] <= m_hwrite[i];
          pend_size[i]  <= m_hsize[i];
        end else if (replay[i]) begin
          pend_vld[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_addr  <= '0;
      hold_write <= 1'b0;
      hold_size  <= 3'd0;
    end else begin
      hold_addr  <= bus_addr;
      hold_write <= bus_write;
      hold_size  <= bus_size;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dph_vld <= 1'b0;
      dph_mst <= RESET_OWNER;
    end else if (s_hready) begin
      dph_vld <= bus_trans[1];
      dph_mst <= own;
    end
  end

  // The exit edge picks up whatever hmsel says then, so a bounce back is honoured.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st  <= RUN;
      own <= RESET_OWNER;
    end else begin
      case (st)
        RUN: begin
          if (req_mst != own) st <= DRAIN;
        end
        DRAIN: begin
          if (!dph_vld || s_hready) begin
            st  <= RUN;
            own <= req_mst;
          end
        end
        default: st <= RUN;
      endcase
    end
  end

endmodule
